// File: rtl/adder_bist.sv
// Exhaustive built-in self-test for a WIDTH-bit ripple-carry adder: drives every {a,b,cin}
// and checks {cout,sum}. Define ADDER_BIST_STOP_ON_FAIL_EN to halt on the first mismatch.
module adder_bist #(
  parameter int WIDTH = 1,
  parameter int ERR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_cout,
  output logic [WIDTH-1:0]   tst_a,
  output logic [WIDTH-1:0]   tst_b,
  output logic               tst_cin,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH:0]   fail_vec
);

  localparam int VW = 2*WIDTH + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t          state;
  logic [VW-1:0]   vec;
  logic [WIDTH:0]  expected;
  logic            mismatch;
  logic            last_vec;

  // Reference is taken from the registered operands, so it lines up with the
  // adder response that has had the whole CHECK cycle to settle.
  always_comb begin
    expected = {1'b0, tst_a} + {1'b0, tst_b} + (WIDTH+1)'(tst_cin);
    mismatch = ({dut_cout, dut_sum} != expected);
    last_vec = &vec;
  end

  // NOTE: every register here is state, so all are written with non-blocking
  // assignments and all (including the vector counter) are cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      vec       <= '0;
      tst_a     <= '0;
      tst_b     <= '0;
      tst_cin   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      // Status flags trail the state by one edge; an accepted start overrides below.
      busy <= (state == DRIVE) || (state == CHECK);
      done <= (state == DONE);
      pass <= (state == DONE) && (err_count == '0);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            state     <= DRIVE;
          end
        end

        DRIVE: begin
          {tst_a, tst_b, tst_cin} <= vec;
          state                   <= CHECK;
        end

        CHECK: begin
          if (mismatch) begin
            if (!(&err_count)) err_count <= err_count + ERR_W'(1);
            // err_count never wraps, so zero reliably marks the first mismatch.
            if (err_count == '0) fail_vec <= {tst_a, tst_b, tst_cin};
          end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
          if (mismatch || last_vec) begin
`else
          if (last_vec) begin
`endif
            state <= DONE;
          end else begin
            vec   <= vec + VW'(1);
            state <= DRIVE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: three instances (4-bit, 1-bit, 1-bit with 2-bit counter)
// driven by a bench adder model with selectable faults, checked against a vector-level reference.
module tb_adder_bist;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_v [3];
  int   mode_v  [3];

  always #5 clk = ~clk;

  // instance 0: WIDTH=1 ERR_W=16
  logic       a0, b0, c0, s0, co0, busy0, done0, pass0;
  logic [15:0] err0;
  logic [2:0]  fv0;
  // instance 1: WIDTH=4 ERR_W=16
  logic [3:0]  a1, b1, s1;
  logic        c1, co1, busy1, done1, pass1;
  logic [15:0] err1;
  logic [8:0]  fv1;
  // instance 2: WIDTH=1 ERR_W=2
  logic       a2, b2, c2, s2, co2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [2:0] fv2;

  adder_bist #(.WIDTH(1), .ERR_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .dut_sum(s0), .dut_cout(co0),
    .tst_a(a0), .tst_b(b0), .tst_cin(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fv0));

  adder_bist #(.WIDTH(4), .ERR_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .dut_sum(s1), .dut_cout(co1),
    .tst_a(a1), .tst_b(b1), .tst_cin(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1));

  adder_bist #(.WIDTH(1), .ERR_W(2)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .dut_sum(s2), .dut_cout(co2),
    .tst_a(a2), .tst_b(b2), .tst_cin(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fv2));

  // Adder under test: mode 0 correct, 1 carry-out stuck at 0, 2 whole result inverted.
  function automatic int adder_out(input int w, input int mode, input int a, input int b, input int cin);
    int s;
    s = a + b + cin;
    case (mode)
      1:       return s & ((1 << w) - 1);
      2:       return (~s) & ((1 << (w + 1)) - 1);
      default: return s;
    endcase
  endfunction

  int r0, r1, r2;
  always_comb begin
    r0  = adder_out(1, mode_v[0], int'(a0), int'(b0), int'(c0));
    s0  = r0[0];
    co0 = r0[1];
    r1  = adder_out(4, mode_v[1], int'(a1), int'(b1), int'(c1));
    s1  = r1[3:0];
    co1 = r1[4];
    r2  = adder_out(1, mode_v[2], int'(a2), int'(b2), int'(c2));
    s2  = r2[0];
    co2 = r2[1];
  end

  // Uniform views of the three instances, indexed by instance number.
  logic [8:0]  tst_v  [3];
  logic [15:0] err_v  [3];
  logic [8:0]  fv_v   [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        pass_v [3];

  assign tst_v[0] = 9'({a0, b0, c0});
  assign tst_v[1] = {a1, b1, c1};
  assign tst_v[2] = 9'({a2, b2, c2});
  assign err_v[0] = err0;
  assign err_v[1] = err1;
  assign err_v[2] = 16'(err2);
  assign fv_v[0]  = 9'(fv0);
  assign fv_v[1]  = fv1;
  assign fv_v[2]  = 9'(fv2);
  assign busy_v[0] = busy0;
  assign busy_v[1] = busy1;
  assign busy_v[2] = busy2;
  assign done_v[0] = done0;
  assign done_v[1] = done1;
  assign done_v[2] = done2;
  assign pass_v[0] = pass0;
  assign pass_v[1] = pass1;
  assign pass_v[2] = pass2;

  int total = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int sel, input string tag);
    check({tag, "_tst"},  32'(tst_v[sel]),  32'h0);
    check({tag, "_busy"}, 32'(busy_v[sel]), 32'h0);
    check({tag, "_done"}, 32'(done_v[sel]), 32'h0);
    check({tag, "_pass"}, 32'(pass_v[sel]), 32'h0);
    check({tag, "_err"},  32'(err_v[sel]),  32'h0);
    check({tag, "_fv"},   32'(fv_v[sel]),   32'h0);
  endtask

  // Runs one full test on instance sel and compares against the vector-level reference.
  // poke=1 pulses start while the run is in DRIVE and then CHECK; both must be ignored.
  task automatic run_check(input int sel, input int w, input int err_w, input int mode,
                           input bit poke, input string tag);
    int nv, mask, errs, fvec, applied, last_v, exp_err, done_edge;
    bit order_ok, overlap, busy_at1;
    mode_v[sel] = mode;
    nv = 1 << (2*w + 1);
    mask = (1 << w) - 1;
    errs = 0; fvec = 0; applied = 0; last_v = 0;
    for (int v = 0; v < nv; v++) begin
      int a, b, c;
      a = v >> (w + 1);
      b = (v >> 1) & mask;
      c = v & 1;
      applied++;
      last_v = v;
      if (adder_out(w, mode, a, b, c) != a + b + c) begin
        if (errs == 0) fvec = v;
        errs++;
        if (STOP) break;
      end
    end
    exp_err = (errs > (1 << err_w) - 1) ? (1 << err_w) - 1 : errs;

    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 start_v[sel] = 1'b1;
    @(posedge clk);
    #1 start_v[sel] = 1'b0;
    check({tag, "_done_clr"}, 32'(done_v[sel]), 32'h0);

    order_ok = 1'b1; overlap = 1'b0; busy_at1 = 1'b0; done_edge = -1;
    for (int n = 1; n <= 4*nv + 8; n++) begin
      @(posedge clk);
      #1;
      if (poke && n == 2) start_v[sel] = 1'b1;
      if (poke && n == 4) start_v[sel] = 1'b0;
      if (n == 1) busy_at1 = busy_v[sel];
      if (busy_v[sel] && done_v[sel]) overlap = 1'b1;
      if ((n % 2 == 1) && ((n - 1) / 2 < applied) && (int'(tst_v[sel]) != (n - 1) / 2))
        order_ok = 1'b0;
      if (done_v[sel]) begin
        done_edge = n;
        break;
      end
    end

    check({tag, "_done_edge"}, 32'(done_edge),    32'(1 + 2*applied));
    check({tag, "_busy_e1"},   32'(busy_at1),     32'h1);
    check({tag, "_overlap"},   32'(overlap),      32'h0);
    check({tag, "_order"},     32'(order_ok),     32'h1);
    check({tag, "_err"},       32'(err_v[sel]),   32'(exp_err));
    check({tag, "_fv"},        32'(fv_v[sel]),    32'(fvec));
    check({tag, "_pass"},      32'(pass_v[sel]),  32'(errs == 0));
    check({tag, "_tst_hold"},  32'(tst_v[sel]),   32'(last_v));
    check({tag, "_busy_end"},  32'(busy_v[sel]),  32'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    check_zero(2, "rst2");
    reset_n = 1'b1;

    run_check(0, 1, 16, 0, 1'b0, "w1_pass");
    run_check(0, 1, 16, 1, 1'b0, "w1_stuck");
    run_check(0, 1, 16, 0, 1'b1, "w1_poke");

    // Reset during CHECK of vector 5 (between edges 11 and 12 after start), then rerun.
    mode_v[0] = 1;
    @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    check_zero(0, "midrst");
    run_check(0, 1, 16, 0, 1'b0, "w1_after_rst");

    run_check(1, 4, 16, 0, 1'b0, "w4_pass");
    check("w4_last_vec", 32'(tst_v[1]), 32'h1FF);

    run_check(2, 1, 2, 2, 1'b0, "sat");

    for (int k = 0; k < 3; k++) begin
      int sel, mode;
      sel  = ($urandom_range(0, 1) == 0) ? 0 : 2;
      mode = $urandom_range(0, 2);
      run_check(sel, 1, (sel == 2) ? 2 : 16, mode, 1'(($urandom_range(0, 1))), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
